// File: rtl/pc_seq_pkg.sv
// Shared definitions for the fetch-side program counter sequencer.
package pc_seq_pkg;

  localparam int DEFAULT_ADDR_W = 10;
  localparam logic [9:0] DEFAULT_RESET_VEC = 10'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: jump beats branch, branch beats a pending squashed
// target, and the sequential pc+1 is the fallback.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              squash,
  input  logic [ADDR_W-1:0] pending,
  output logic [ADDR_W-1:0] next_pc,
  output logic              redirect
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    redirect = jump | branch_taken;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end else if (squash) begin
      next_pc = pending;
    end else begin
      next_pc = pc + ONE;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: issues instruction fetches over a req/ready
// handshake, handles stall/halt and squashes fetches overtaken by a redirect.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W    = DEFAULT_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEFAULT_RESET_VEC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [ADDR_W-1:0] pending, pending_nxt;
  logic [ADDR_W-1:0] instr_pc_nxt;
  logic [ADDR_W-1:0] sel_pc;
  logic              squash, squash_nxt;
  logic              valid_nxt;
  logic              halt_flag, halt_seen;
  logic              armed;
  logic              redirect;

  // Once halt has been latched, redirects no longer reach the selector.
  pc_next_sel #(.ADDR_W(ADDR_W)) u_next_sel (
    .pc            (pc),
    .jump          (jump & ~halt_flag),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken & ~halt_flag),
    .branch_target (branch_target),
    .squash        (squash),
    .pending       (pending),
    .next_pc       (sel_pc),
    .redirect      (redirect)
  );

  assign imem_addr = pc;
  assign halt_seen = halt_flag | halt;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pending_nxt  = pending;
    squash_nxt   = squash;
    valid_nxt    = 1'b0;
    instr_pc_nxt = instr_pc;
    case (state)
      // armed gives one full cycle in IDLE after reset release
      IDLE: begin
        if (armed) begin
          if (halt_seen)  state_nxt = HALT;
          else if (stall) state_nxt = STALL;
          else            state_nxt = REQ;
        end
      end
      REQ: begin
        if (imem_ready) begin
          pc_nxt     = sel_pc;
          squash_nxt = 1'b0;
          if (!(squash || redirect)) begin
            valid_nxt    = 1'b1;
            instr_pc_nxt = pc;
          end
          if (halt_seen)  state_nxt = HALT;
          else if (stall) state_nxt = STALL;
          else            state_nxt = REQ;
        end else if (redirect) begin
          pending_nxt = sel_pc;
          squash_nxt  = 1'b1;
        end
      end
      STALL: begin
        if (redirect) pc_nxt = sel_pc;
        if (halt_seen)  state_nxt = HALT;
        else if (stall) state_nxt = STALL;
        else            state_nxt = REQ;
      end
      HALT: begin
        state_nxt = HALT;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request and status outputs are registered off the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_VEC;
      pending     <= '0;
      squash      <= 1'b0;
      halt_flag   <= 1'b0;
      armed       <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      halted      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pending     <= pending_nxt;
      squash      <= squash_nxt;
      halt_flag   <= halt_flag | halt;
      armed       <= 1'b1;
      imem_req    <= (state_nxt == REQ);
      instr_valid <= valid_nxt;
      instr_pc    <= instr_pc_nxt;
      halted      <= (state_nxt == HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses and delivered
// instruction PCs are queued up front and popped by a negedge monitor.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [9:0] branch_target = '0;
  logic       jump = 1'b0;
  logic [9:0] jump_target = '0;
  logic       halt = 1'b0;
  logic       imem_ready = 1'b0;
  logic       imem_req;
  logic [9:0] imem_addr;
  logic       instr_valid;
  logic [9:0] instr_pc;
  logic       halted;

  int         n_vectors = 0;
  int         n_miscompares = 0;
  logic [9:0] exp_req_q[$];
  logic [9:0] exp_instr_q[$];

  pc_sequencer #(.ADDR_W(10), .RESET_VEC(10'd0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .halt          (halt),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic [9:0] bt,
                               input logic jp, input logic [9:0] jt, input logic hl, input logic rdy);
    stall         = st;
    branch_taken  = br;
    branch_target = bt;
    jump          = jp;
    jump_target   = jt;
    halt          = hl;
    imem_ready    = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A handshake happens at the coming posedge whenever req and ready are both high.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n && imem_req && imem_ready) begin
      checkOutput("req_queue_has_entry", 32'(exp_req_q.size() > 0), 1);
      if (exp_req_q.size() > 0) begin
        e = exp_req_q.pop_front();
        checkOutput("handshake_addr", imem_addr, e);
      end
    end
    if (rst_n && instr_valid) begin
      checkOutput("instr_queue_has_entry", 32'(exp_instr_q.size() > 0), 1);
      if (exp_instr_q.size() > 0) begin
        e = exp_instr_q.pop_front();
        checkOutput("instr_pc", instr_pc, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_imem_req", imem_req, 0);
    checkOutput("rst_instr_valid", instr_valid, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_imem_addr", imem_addr, 0);
    checkOutput("rst_instr_pc", instr_pc, 0);

    exp_req_q   = {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7, 10'd8,
                   10'd100, 10'd200, 10'd201, 10'd1023, 10'd0, 10'd50, 10'd51};
    exp_instr_q = {10'd0, 10'd1, 10'd2, 10'd3, 10'd4, 10'd5, 10'd6, 10'd7,
                   10'd200, 10'd1023, 10'd0, 10'd50, 10'd51};

    // Sequential fetch with ready tied high
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("idle_imem_req", imem_req, 0);
    tick();
    checkOutput("first_imem_req", imem_req, 1);
    checkOutput("first_imem_addr", imem_addr, 0);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("seq_addr5", imem_addr, 5);

    // Three wait states at address 5
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checkOutput("wait_imem_req", imem_req, 1);
      checkOutput("wait_imem_addr", imem_addr, 5);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("wait_done_valid", instr_valid, 1);
    checkOutput("wait_done_pc", instr_pc, 5);
    checkOutput("wait_done_addr", imem_addr, 6);
    tick();
    tick();
    checkOutput("pre_redirect_addr", imem_addr, 8);

    // Branch while the fetch at 8 is outstanding
    applyStimulus(0, 1, 10'd100, 0, 0, 0, 0);
    tick();
    checkOutput("squash_hold_addr", imem_addr, 8);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("squash_no_valid", instr_valid, 0);
    checkOutput("branch_addr", imem_addr, 100);

    // Jump and branch together: jump wins
    applyStimulus(0, 1, 10'd300, 1, 10'd200, 0, 1);
    tick();
    checkOutput("jump_prio_addr", imem_addr, 200);
    checkOutput("jump_prio_no_valid", instr_valid, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("after_jump_addr", imem_addr, 201);

    // Wrap from 1023 to 0
    applyStimulus(0, 0, 0, 1, 10'd1023, 0, 1);
    tick();
    checkOutput("top_addr", imem_addr, 1023);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("wrap_addr", imem_addr, 0);

    // Stall for four cycles with a jump inside the stall
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("stall_req_0", imem_req, 0);
    tick();
    checkOutput("stall_req_1", imem_req, 0);
    applyStimulus(1, 0, 0, 1, 10'd50, 0, 1);
    tick();
    checkOutput("stall_req_2", imem_req, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("stall_req_3", imem_req, 0);
    checkOutput("stall_jump_pc", imem_addr, 50);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("unstall_req", imem_req, 1);
    checkOutput("unstall_addr", imem_addr, 50);
    tick();

    // Halt raised during a wait state
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 0);
    tick();
    checkOutput("halt_pending_halted", halted, 0);
    checkOutput("halt_pending_req", imem_req, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("halt_final_valid", instr_valid, 1);
    checkOutput("halt_final_pc", instr_pc, 51);
    checkOutput("halted", halted, 1);
    checkOutput("halted_req", imem_req, 0);
    applyStimulus(0, 1, 10'd9, 1, 10'd7, 0, 1);
    tick();
    tick();
    checkOutput("halt_sticky", halted, 1);
    checkOutput("halt_req_off", imem_req, 0);
    checkOutput("halt_pc_frozen", imem_addr, 52);
    checkOutput("halt_no_valid", instr_valid, 0);
    checkOutput("req_queue_drained", exp_req_q.size(), 0);
    checkOutput("instr_queue_drained", exp_instr_q.size(), 0);

    // Reset out of HALT, then async reset in the middle of a request
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("rereset_halted", halted, 0);
    exp_req_q.push_back(10'd0);
    exp_instr_q.push_back(10'd0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("midreq_req", imem_req, 1);
    checkOutput("midreq_addr", imem_addr, 1);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", imem_req, 0);
    checkOutput("async_rst_addr", imem_addr, 0);
    checkOutput("async_rst_valid", instr_valid, 0);
    checkOutput("final_req_queue_drained", exp_req_q.size(), 0);
    checkOutput("final_instr_queue_drained", exp_instr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
